// File: rtl/approx_divider_seq.sv
// Sequential approximate unsigned divider: leading-one segments of a (2*NUM bits) and
// b (NUM bits) are divided by a restoring divider, then rescaled and saturated to 16 bits.
module approx_divider_seq #(
    parameter int NUM = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic        ovf,
    output logic        dz
);
    localparam int DW = 2 * NUM;
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [2:0] {S_IDLE, S_NORM, S_DIV, S_SCALE, S_DONE} state_t;

    state_t          r_state, w_next;
    logic            r_rdy;
    logic [31:0]     r_a;
    logic [15:0]     r_b;
    logic [DW-1:0]   r_ma, r_quo;
    logic [NUM-1:0]  r_mb, r_rem;
    logic [4:0]      r_sa;
    logic [3:0]      r_sb;
    logic            r_dzn;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_q;
    logic            r_ovf, r_dz;

    logic [4:0]      w_ka, w_sa;
    logic [3:0]      w_kb, w_sb;
    logic [DW-1:0]   w_ma;
    logic [NUM-1:0]  w_mb, w_rem_nx;
    logic [NUM:0]    w_trial, w_diff;
    logic            w_ge;
    logic [47:0]     w_qx, w_res;
    logic            w_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rdy   <= (w_next == S_IDLE);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid && r_rdy) w_next = S_NORM;
            S_NORM:  w_next = S_DIV;
            S_DIV:   if (r_cnt == CW'(DW - 1)) w_next = S_SCALE;
            S_SCALE: w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Leading-one indices; 0 and 1 both map to index 0.
    always_comb begin
        w_ka = '0;
        for (int i = 1; i < 32; i++)
            if (r_a[i]) w_ka = 5'(i);
        w_kb = '0;
        for (int i = 1; i < 16; i++)
            if (r_b[i]) w_kb = 4'(i);
    end

    assign w_sa = (w_ka > 5'(DW - 1))  ? w_ka - 5'(DW - 1)  : '0;
    assign w_sb = (w_kb > 4'(NUM - 1)) ? w_kb - 4'(NUM - 1) : '0;
    assign w_ma = DW'(r_a >> w_sa);
    assign w_mb = NUM'(r_b >> w_sb);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_trial  = {r_rem, r_ma[DW-1]};
    assign w_diff   = w_trial - {1'b0, r_mb};
    assign w_ge     = (w_trial >= {1'b0, r_mb});
    assign w_rem_nx = w_ge ? NUM'(w_diff) : NUM'(w_trial);

    assign w_qx  = 48'(r_quo);
    assign w_res = (r_sa >= {1'b0, r_sb}) ? (w_qx << (r_sa - {1'b0, r_sb}))
                                          : (w_qx >> ({1'b0, r_sb} - r_sa));
    assign w_sat = |w_res[47:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_ma  <= '0;
            r_mb  <= '0;
            r_sa  <= '0;
            r_sb  <= '0;
            r_dzn <= 1'b0;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_ovf <= 1'b0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid && r_rdy) begin
                    r_a <= a;
                    r_b <= b;
                end
                S_NORM: begin
                    r_ma  <= w_ma;
                    r_mb  <= w_mb;
                    r_sa  <= w_sa;
                    r_sb  <= w_sb;
                    r_dzn <= (r_b == '0);
                    r_rem <= '0;
                    r_quo <= '0;
                    r_cnt <= '0;
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_ma  <= r_ma << 1;
                    r_quo <= {r_quo[DW-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_SCALE: begin
                    r_q   <= (r_dzn || w_sat) ? 16'hFFFF : w_res[15:0];
                    r_ovf <= !r_dzn && w_sat;
                    r_dz  <= r_dzn;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_rdy;
    assign out_valid = (r_state == S_DONE);
    assign q         = r_q;
    assign ovf       = r_ovf;
    assign dz        = r_dz;
endmodule

// File: tb/tb_approx_divider_seq.sv
// Randomized scoreboard bench for approx_divider_seq: driver pushes expected results,
// a negedge monitor checks latency, hold-under-backpressure and the accepted result.
module tb_approx_divider_seq;
    localparam int NUM = 6;
    localparam int LAT = 2 * NUM + 2;
    localparam int GAP = 2 * NUM + 4;

    typedef struct {
        logic [15:0] q;
        logic        ovf;
        logic        dz;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready, out_valid, ovf, dz;
    logic [15:0] q;

    approx_divider_seq #(.NUM(NUM)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   last_xfer = -1000;
    int   or_mode = 0;   // 0: out_ready high, 1: low, 2: random

    function automatic void ck(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    function automatic exp_t mk(input logic [15:0] eq, input logic eovf, input logic edz);
        exp_t e;
        e.q = eq; e.ovf = eovf; e.dz = edz; e.t = 0;
        return e;
    endfunction

    // Reference: segment both operands by plain shifts, integer-divide, rescale, saturate.
    function automatic exp_t model(input logic [31:0] ma_in, input logic [15:0] mb_in);
        exp_t e;
        int ka, kb, sa, sbv, sh;
        longint unsigned ma, mb, qr, res;
        e = mk(16'h0, 1'b0, 1'b0);
        if (mb_in == 0) return mk(16'hFFFF, 1'b0, 1'b1);
        ka = 0;
        while (ka < 31 && (ma_in >> (ka + 1)) != 0) ka++;
        kb = 0;
        while (kb < 15 && (mb_in >> (kb + 1)) != 0) kb++;
        sa  = (ka > 2 * NUM - 1) ? ka - (2 * NUM - 1) : 0;
        sbv = (kb > NUM - 1) ? kb - (NUM - 1) : 0;
        ma  = longint'(ma_in >> sa);
        mb  = longint'(mb_in >> sbv);
        qr  = ma / mb;
        sh  = sa - sbv;
        res = (sh >= 0) ? (qr << sh) : (qr >> (-sh));
        if (res > 64'hFFFF) e = mk(16'hFFFF, 1'b1, 1'b0);
        else                e.q = res[15:0];
        return e;
    endfunction

    task automatic issue(input logic [31:0] ia, input logic [15:0] ib, input exp_t e);
        int w;
        @(negedge clk);
        a = ia; b = ib; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            ck("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.t = cyc;
        ck("issue_gap_ok", 64'(cyc - last_xfer >= GAP), 64'd1);
        last_xfer = cyc;
        sb.push_back(e);
    endtask

    // out_ready changes only just after a rising edge so the monitor sees a settled value.
    initial forever begin
        @(posedge clk);
        #2;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    initial begin
        logic        pv, pr, po, pd;
        logic [15:0] pq;
        exp_t        e;
        pv = 1'b0; pr = 1'b0; po = 1'b0; pd = 1'b0; pq = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!pv) begin
                        if (sb.size() == 0) begin
                            n_vec++; n_err++;
                            $display("FAIL spurious_out_valid: got out_valid=1 expected no result pending (cycle %0d)", cyc);
                        end else begin
                            ck("latency", 64'(cyc - sb[0].t), 64'(LAT));
                        end
                    end else if (!pr) begin
                        ck("hold_q", 64'(q), 64'(pq));
                        ck("hold_flags", 64'({ovf, dz}), 64'({po, pd}));
                    end
                    if (out_ready && sb.size() > 0) begin
                        e = sb.pop_front();
                        ck("q", 64'(q), 64'(e.q));
                        ck("ovf", 64'(ovf), 64'(e.ovf));
                        ck("dz", 64'(dz), 64'(e.dz));
                    end
                end
                pv = out_valid; pr = out_ready; pq = q; po = ovf; pd = dz;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    logic [31:0] da [8] = '{32'd100, 32'd65536, 32'd1000000, 32'hFFFFFFFF, 32'd5, 32'd5, 32'd100, 32'd0};
    logic [15:0] db [8] = '{16'd7, 16'd3, 16'd1000, 16'd1, 16'hFFFF, 16'd0, 16'd7, 16'd9};
    logic [15:0] dq [8] = '{16'd14, 16'd21824, 16'd1008, 16'hFFFF, 16'd0, 16'hFFFF, 16'd14, 16'd0};
    logic        dovf [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        ddz  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        ck("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [15:0] rb;
        int w;

        repeat (3) @(posedge clk);
        @(negedge clk);
        ck("rst_in_ready", 64'(in_ready), 64'd0);
        ck("rst_out_valid", 64'(out_valid), 64'd0);
        ck("rst_outputs", 64'({q, ovf, dz}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ck("in_ready_after_rst", 64'(in_ready), 64'd1);

        for (int i = 0; i < 8; i++) issue(da[i], db[i], mk(dq[i], dovf[i], ddz[i]));
        drain();

        // Back-pressure: hold the result 20 cycles while poking in_valid.
        or_mode = 1;
        issue(32'd100, 16'd7, mk(16'd14, 1'b0, 1'b0));
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        ck("bp_out_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ck("bp_out_valid", 64'(out_valid), 64'd1);
            ck("bp_q", 64'(q), 64'd14);
            ck("bp_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'($urandom_range(0, 1));
            a = $urandom;
            b = 16'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        or_mode = 0;
        @(posedge clk);
        #3;
        @(posedge clk);
        #1;
        ck("release_out_valid", 64'(out_valid), 64'd0);
        ck("release_in_ready", 64'(in_ready), 64'd1);
        repeat (20) @(negedge clk);

        // Reset in the middle of the divide loop drops the operation.
        issue(32'd100, 16'd7, mk(16'd14, 1'b0, 1'b0));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        ck("midrst_out_valid", 64'(out_valid), 64'd0);
        ck("midrst_in_ready", 64'(in_ready), 64'd0);
        ck("midrst_q", 64'({q, ovf, dz}), 64'd0);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        issue(32'd100, 16'd7, mk(16'd14, 1'b0, 1'b0));
        drain();

        // Randomized operands with random back-pressure.
        or_mode = 2;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(16, 31));
            issue(ra, rb, model(ra, rb));
        end
        or_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
